mesh_ej_arb: RTL and testbench
==============================

# mesh_ej_arb

Ejection-port arbiter for one node of the 8x8 mesh. It merges the 14 inbound line channels into the node's single ejection port: 7 same-row (X) and 7 same-column (Y), each arriving from its IRS_N pipe. Arbitration is two-class (QoS high over low), with a round-robin pointer per class and age-based promotion so low-QoS traffic cannot starve. The output is one registered valid/ready stage, so the node sees a timing-clean interface.

## Interface
- NUM_REQ, 14, number of inbound channels; index 0-6 = X line, 7-13 = Y line
- PYLD_W, 64, payload width per channel; the packet fields are carried opaque
- AGE_MAX, 15, age at which a waiting low-QoS requester is promoted; range 1..255
- AGE_W, $clog2(AGE_MAX+1), width of each age counter (derived)

Ports:
- clk  in  1  clock; all logic is rising-edge
- rst  in  1  reset, asynchronous, active-high
- req_vld  in  NUM_REQ  per-channel valid
- req_qos  in  NUM_REQ  per-channel QoS bit; 1 = high
- req_pyld  in  NUM_REQ*PYLD_W  payloads; channel i occupies bits [i*PYLD_W +: PYLD_W]
- req_rdy  out  NUM_REQ  per-channel ready; one-hot or zero
- out_vld  out  1  ejection valid (registered)
- out_pyld  out  PYLD_W  ejection payload (registered)
- out_idx  out  $clog2(NUM_REQ)  channel index of the held packet (registered)
- out_rdy  in  1  ejection ready from the node

## Operation
- Output stage has two states.
  - EMPTY (out_vld=0).
  - FULL (out_vld=1).
- load = req_vld != 0 && (EMPTY || out_rdy).
- Transitions:
  - EMPTY→FULL on load.
  - FULL→FULL on out_rdy && load.
  - FULL→EMPTY on out_rdy && !load.
  - FULL holds on !out_rdy.
- Effective class per channel: hi[i] = req_vld[i] && (req_qos[i] || age[i]==AGE_MAX).
- Selection (combinational):
  - If any hi[i] is set, round-robin over hi using ptr_hi.
  - Otherwise, round-robin over req_vld using ptr_lo.
  - Round-robin = first set bit at index ≥ ptr, wrapping from NUM_REQ-1 to 0.
- req_rdy[g] = load for the selected g; every other bit is 0. A transfer on channel i is req_vld[i] && req_rdy[i].
- On load:
  - out_pyld ← req_pyld[g], out_idx ← g.
  - The pointer of the winning class ← (g+1) mod NUM_REQ. The other class's pointer is unchanged.
  - A promoted low-QoS winner advances ptr_hi.
- Age counters, one per channel, updated every cycle:
  - Cleared if channel i transfers, or if !req_vld[i].
  - Else incremented if < AGE_MAX.
  - Else held (saturating at AGE_MAX).
  - Counters count while the output is stalled.
- out_pyld and out_idx change only on load. With !out_rdy they stay bit-stable.
- Reset values:
  - out_vld=0, out_pyld=0, out_idx=0.
  - ptr_hi=ptr_lo=0, all age=0.
  - req_rdy=0 combinationally, since out_vld=0 and req_vld is ignored while rst=1.

## Timing
- Latency: a transfer at edge N makes out_vld=1 with that payload after edge N. Throughput is 1 packet/cycle with out_rdy held at 1.
- req_rdy depends combinationally on req_vld, req_qos, out_rdy and state. There is no combinational path from req_vld to req_vld.
- The backpressure path from out_rdy to req_rdy is combinational, so full throughput needs no bubble.
- Simultaneous pop and load in FULL: the new payload replaces the old at the same edge, with no gap.
- An upstream channel may drop req_vld without a transfer. Its age clears and no state is corrupted.
- rst asserted mid-packet: the held packet is discarded, out_vld=0 asynchronously, and pointers and ages return to 0. The first edge after rst deasserts may load.
- Age reaching AGE_MAX makes that channel eligible in the same cycle the counter shows AGE_MAX.

## Test plan
- Reset/basic: assert rst with req_vld=all-1, out_rdy=1 → out_vld=0 and req_rdy=0 throughout. Release, drive only req_vld[5] with pyld 0xA5 → req_rdy[5]=1 that cycle; next cycle out_vld=1, out_pyld=0xA5, out_idx=5.
- Round-robin: channels 1, 4, 9 valid with qos=0, out_rdy=1, AGE_MAX=15 → grant order 1, 4, 9, 1, 4, …; out_vld continuously 1.
- QoS priority: channel 2 low and channel 11 high, both held valid → channel 11 wins every cycle. Channel 2's age rises 1, 2, …; once it reaches AGE_MAX it is promoted and granted, then its age = 0.
- Starvation bound with AGE_MAX=3: channels 0, 7 high continuously and channel 3 low → channel 3 is granted within 3 + 3 cycles of first valid, and never waits longer thereafter.
- Backpressure: out_rdy=0 for 5 cycles with channels 0 and 1 valid → req_rdy=0, and out_pyld/out_idx are stable during the stall. When out_rdy rises, the pop and the next load occur at the same edge.
- Reset mid-stream: FULL with out_rdy=0, assert rst asynchronously between edges → out_vld falls immediately; after release, grant order restarts from index 0.

Source files
------------

// File: rtl/mesh_ej_arb.sv
// mesh_ej_arb: ejection-port arbiter for one mesh node.
// Merges NUM_REQ inbound line channels (0..6 = X line, 7..13 = Y line) into a single
// registered valid/ready ejection stage. Two QoS classes, a round-robin pointer per
// class, and per-channel age counters that promote a waiting low-QoS channel to the
// high class once its age reaches AGE_MAX.
//
// Ports:
//   clk       in   clock, rising edge
//   rst       in   asynchronous active-high reset
//   req_vld   in   [NUM_REQ]          per-channel valid
//   req_qos   in   [NUM_REQ]          per-channel QoS, 1 = high
//   req_pyld  in   [NUM_REQ*PYLD_W]   payloads, channel i at [i*PYLD_W +: PYLD_W]
//   req_rdy   out  [NUM_REQ]          per-channel ready, one-hot or zero
//   out_vld   out  1                  ejection valid (registered)
//   out_pyld  out  [PYLD_W]           ejection payload (registered)
//   out_idx   out  [clog2(NUM_REQ)]   source channel of the held packet (registered)
//   out_rdy   in   1                  ejection ready from the node
module mesh_ej_arb #(
  parameter int unsigned NUM_REQ = 14,
  parameter int unsigned PYLD_W  = 64,
  parameter int unsigned AGE_MAX = 15,
  parameter int unsigned AGE_W   = $clog2(AGE_MAX + 1)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_REQ-1:0]           req_vld,
  input  logic [NUM_REQ-1:0]           req_qos,
  input  logic [NUM_REQ*PYLD_W-1:0]    req_pyld,
  output logic [NUM_REQ-1:0]           req_rdy,
  output logic                         out_vld,
  output logic [PYLD_W-1:0]            out_pyld,
  output logic [$clog2(NUM_REQ)-1:0]   out_idx,
  input  logic                         out_rdy
);

  localparam int unsigned IdxW = $clog2(NUM_REQ);

  typedef enum logic {StEmpty, StFull} state_e;

  state_e              state_q, state_d;
  logic [PYLD_W-1:0]   pyld_q;
  logic [IdxW-1:0]     idx_q;
  logic [IdxW-1:0]     ptr_hi_q, ptr_lo_q;
  logic [AGE_W-1:0]    age_q [NUM_REQ];
  logic [AGE_W-1:0]    age_d [NUM_REQ];

  logic [NUM_REQ-1:0]  hi;
  logic                hi_any;
  logic                load;
  logic [NUM_REQ-1:0]  sel_mask;
  logic [IdxW-1:0]     sel_ptr;
  logic [IdxW-1:0]     gnt;
  logic [IdxW-1:0]     gnt_nxt;
  logic [PYLD_W-1:0]   gnt_pyld;

  // First set bit at index >= ptr, wrapping from NUM_REQ-1 back to 0.
  function automatic logic [IdxW-1:0] rr_pick(input logic [NUM_REQ-1:0] mask,
                                               input logic [IdxW-1:0]    ptr);
    logic [IdxW-1:0] pick;
    logic [IdxW-1:0] idx_n;
    logic            found;
    int unsigned     idx;
    pick  = '0;
    found = 1'b0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      idx = 32'(ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      idx_n = IdxW'(idx);
      if (!found && mask[idx_n]) begin
        found = 1'b1;
        pick  = idx_n;
      end
    end
    return pick;
  endfunction

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      hi[i] = req_vld[i] && (req_qos[i] || (age_q[i] == AGE_W'(AGE_MAX)));
    end
    hi_any   = |hi;
    // rst gates load so req_rdy stays low while reset is held.
    load     = !rst && (|req_vld) && ((state_q == StEmpty) || out_rdy);
    sel_mask = hi_any ? hi : req_vld;
    sel_ptr  = hi_any ? ptr_hi_q : ptr_lo_q;
    gnt      = rr_pick(sel_mask, sel_ptr);
    gnt_nxt  = (gnt == IdxW'(NUM_REQ - 1)) ? '0 : gnt + 1'b1;
    req_rdy  = load ? (NUM_REQ'(1) << gnt) : '0;
    gnt_pyld = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt == IdxW'(i)) gnt_pyld = req_pyld[i*PYLD_W +: PYLD_W];
    end
  end

  // Ages clear on transfer or when the channel drops valid, otherwise saturate upward.
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      age_d[i] = age_q[i];
      if (!req_vld[i] || req_rdy[i]) begin
        age_d[i] = '0;
      end else if (age_q[i] != AGE_W'(AGE_MAX)) begin
        age_d[i] = age_q[i] + 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StEmpty: if (load) state_d = StFull;
      StFull:  if (out_rdy) state_d = load ? StFull : StEmpty;
      default: state_d = StEmpty;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StEmpty;
      pyld_q   <= '0;
      idx_q    <= '0;
      ptr_hi_q <= '0;
      ptr_lo_q <= '0;
      for (int i = 0; i < NUM_REQ; i++) age_q[i] <= '0;
    end else begin
      state_q <= state_d;
      for (int i = 0; i < NUM_REQ; i++) age_q[i] <= age_d[i];
      if (load) begin
        pyld_q <= gnt_pyld;
        idx_q  <= gnt;
        // A promoted low-QoS winner belongs to the high class, so it advances ptr_hi.
        if (hi_any) ptr_hi_q <= gnt_nxt;
        else        ptr_lo_q <= gnt_nxt;
      end
    end
  end

  assign out_vld  = (state_q == StFull);
  assign out_pyld = pyld_q;
  assign out_idx  = idx_q;

endmodule

// File: tb/tb_mesh_ej_arb.sv
// Directed self-checking bench for mesh_ej_arb. Instance dut uses AGE_MAX=15; instance
// dut3 shares the same stimulus with AGE_MAX=3 and is checked in the starvation phase.
module tb_mesh_ej_arb;

  localparam int NR = 14;
  localparam int PW = 64;

  logic             clk = 1'b0;
  logic             rst;
  logic [NR-1:0]    req_vld;
  logic [NR-1:0]    req_qos;
  logic [NR*PW-1:0] req_pyld;
  logic             out_rdy;

  logic [NR-1:0]    req_rdy;
  logic             out_vld;
  logic [PW-1:0]    out_pyld;
  logic [3:0]       out_idx;

  logic [NR-1:0]    req_rdy_b;
  logic             out_vld_b;
  logic [PW-1:0]    out_pyld_b;
  logic [3:0]       out_idx_b;

  int total = 0;
  int bad   = 0;

  int rr_exp [6]  = '{1, 4, 9, 1, 4, 9};
  int st_exp [14] = '{0, 7, 0, 3, 7, 0, 7, 0, 3, 7, 0, 7, 0, 3};

  always #5 clk = ~clk;

  mesh_ej_arb #(.NUM_REQ(NR), .PYLD_W(PW), .AGE_MAX(15)) dut (
    .clk      (clk),
    .rst      (rst),
    .req_vld  (req_vld),
    .req_qos  (req_qos),
    .req_pyld (req_pyld),
    .req_rdy  (req_rdy),
    .out_vld  (out_vld),
    .out_pyld (out_pyld),
    .out_idx  (out_idx),
    .out_rdy  (out_rdy)
  );

  mesh_ej_arb #(.NUM_REQ(NR), .PYLD_W(PW), .AGE_MAX(3)) dut3 (
    .clk      (clk),
    .rst      (rst),
    .req_vld  (req_vld),
    .req_qos  (req_qos),
    .req_pyld (req_pyld),
    .req_rdy  (req_rdy_b),
    .out_vld  (out_vld_b),
    .out_pyld (out_pyld_b),
    .out_idx  (out_idx_b),
    .out_rdy  (out_rdy)
  );

  function automatic logic [63:0] oh(input int k);
    return 64'(1) << k;
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst     = 1'b1;
    req_vld = '0;
    req_qos = '0;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst     = 1'b1;
    req_vld = '1;
    req_qos = '0;
    out_rdy = 1'b1;
    for (int i = 0; i < NR; i++) req_pyld[i*PW +: PW] = 64'h100 + 64'(i);

    // Reset: nothing granted, output empty, even with every channel valid.
    #1;
    chk("rst_vld", 64'(out_vld), 64'd0);
    chk("rst_rdy", 64'(req_rdy), 64'd0);
    tick();
    tick();
    chk("rst_vld2", 64'(out_vld), 64'd0);
    chk("rst_rdy2", 64'(req_rdy), 64'd0);
    chk("rst_pyld", out_pyld, 64'd0);

    // Single request on channel 5.
    rst = 1'b0;
    req_vld = 14'h0020;
    req_pyld[5*PW +: PW] = 64'hA5;
    #1;
    chk("one_rdy", 64'(req_rdy), oh(5));
    tick();
    chk("one_vld", 64'(out_vld), 64'd1);
    chk("one_pyld", out_pyld, 64'hA5);
    chk("one_idx", 64'(out_idx), 64'd5);
    req_vld = '0;
    req_pyld[5*PW +: PW] = 64'h105;
    tick();
    chk("one_drain", 64'(out_vld), 64'd0);

    // Round-robin among low-QoS channels 1, 4, 9.
    do_reset();
    req_vld = 14'h0212;
    for (int k = 0; k < 6; k++) begin
      #1;
      chk("rr_rdy", 64'(req_rdy), oh(rr_exp[k]));
      tick();
      chk("rr_idx", 64'(out_idx), 64'(rr_exp[k]));
      chk("rr_pyld", out_pyld, 64'h100 + 64'(rr_exp[k]));
      chk("rr_vld", 64'(out_vld), 64'd1);
    end

    // QoS: 11 high beats 2 low until 2 ages to 15 and is promoted.
    do_reset();
    req_vld = 14'h0804;
    req_qos = 14'h0800;
    for (int k = 0; k < 18; k++) begin
      #1;
      chk("qos_rdy", 64'(req_rdy), oh((k == 15) ? 2 : 11));
      tick();
      chk("qos_idx", 64'(out_idx), (k == 15) ? 64'd2 : 64'd11);
    end

    // Starvation bound with AGE_MAX=3: 0, 7 high, 3 low.
    do_reset();
    req_vld = 14'h0089;
    req_qos = 14'h0081;
    for (int k = 0; k < 14; k++) begin
      #1;
      chk("stv_rdy", 64'(req_rdy_b), oh(st_exp[k]));
      tick();
      chk("stv_idx", 64'(out_idx_b), 64'(st_exp[k]));
      chk("stv_pyld", out_pyld_b, 64'h100 + 64'(st_exp[k]));
      chk("stv_vld", 64'(out_vld_b), 64'd1);
    end

    // Backpressure: hold channel 0's packet for 5 stalled cycles.
    do_reset();
    req_vld = 14'h0003;
    #1;
    chk("bp_rdy0", 64'(req_rdy), oh(0));
    tick();
    chk("bp_idx0", 64'(out_idx), 64'd0);
    out_rdy = 1'b0;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("bp_stall_rdy", 64'(req_rdy), 64'd0);
      tick();
      chk("bp_stall_vld", 64'(out_vld), 64'd1);
      chk("bp_stall_idx", 64'(out_idx), 64'd0);
      chk("bp_stall_pyld", out_pyld, 64'h100);
    end
    out_rdy = 1'b1;
    #1;
    chk("bp_resume_rdy", 64'(req_rdy), oh(1));
    tick();
    chk("bp_resume_vld", 64'(out_vld), 64'd1);
    chk("bp_resume_idx", 64'(out_idx), 64'd1);
    chk("bp_resume_pyld", out_pyld, 64'h101);
    #1;
    chk("bp_next_rdy", 64'(req_rdy), oh(0));
    tick();
    chk("bp_next_idx", 64'(out_idx), 64'd0);

    // Reset mid-stream while FULL and stalled; ptr_lo would otherwise pick 1 next.
    out_rdy = 1'b0;
    tick();
    #3;
    rst = 1'b1;
    #1;
    chk("mid_rst_vld", 64'(out_vld), 64'd0);
    chk("mid_rst_rdy", 64'(req_rdy), 64'd0);
    chk("mid_rst_pyld", out_pyld, 64'd0);
    tick();
    rst = 1'b0;
    out_rdy = 1'b1;
    #1;
    chk("mid_after_rdy", 64'(req_rdy), oh(0));
    tick();
    chk("mid_after_idx", 64'(out_idx), 64'd0);
    chk("mid_after_vld", 64'(out_vld), 64'd1);
    #1;
    chk("mid_after_rdy2", 64'(req_rdy), oh(1));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
